input_conditioner: RTL and testbench

Board-input front end sitting directly upstream of `top`'s processor instance. Synchronizes and debounces the raw centre-button and `sw[0]` inputs and turns the button into a clean, stretched, active-high processor reset. Outputs feed the processor's reset and the display-half select, so bounce or metastability never reaches the core.

---
 rtl/input_conditioner.sv | 129 ++++++++++++
 tb/tb_input_conditioner.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Board-input front end: synchronizes and debounces the raw button and switch,
// and turns the button into a clean, stretched, active-high processor reset.

module input_conditioner_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic stable
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  // Any agreeing cycle clears the count, so only an unbroken run of
  // mismatching samples can move the debounced level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module input_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int RESET_HOLD_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic reset_btn,
  input  logic sw_raw,
  output logic cpu_reset,
  output logic cpu_running,
  output logic btn_press,
  output logic sw_clean
);
  localparam int NUM_LANES = 2;
  localparam int HW        = $clog2(RESET_HOLD_CYCLES + 1);

  typedef enum logic [1:0] {ST_RUN, ST_ASSERT, ST_STRETCH} state_t;

  logic [NUM_LANES-1:0] raw, db;
  assign raw = {sw_raw, reset_btn};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    input_conditioner_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (raw[i]),
      .stable (db[i])
    );
  end

  assign sw_clean = db[1];

  state_t        state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic          btn_prev, rise, fall, press_nxt;

  // Edges of the debounced button level, seen one cycle after it flips.
  assign rise = db[0] & ~btn_prev;
  assign fall = ~db[0] & btn_prev;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    press_nxt = 1'b0;
    case (state)
      ST_RUN: begin
        if (rise) begin
          state_nxt = ST_ASSERT;
          press_nxt = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (fall) begin
          state_nxt = ST_STRETCH;
          hold_nxt  = '0;
        end
      end
      ST_STRETCH: begin
        hold_nxt = hold_cnt + 1'b1;
        // A fresh press wins over the end of the stretch window.
        if (rise) begin
          state_nxt = ST_ASSERT;
          press_nxt = 1'b1;
        end else if (hold_cnt == HW'(RESET_HOLD_CYCLES - 1)) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_STRETCH;
    endcase
  end

  // Outputs are loaded from the next-state decode so they never glitch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_STRETCH;
      hold_cnt    <= '0;
      btn_prev    <= 1'b0;
      btn_press   <= 1'b0;
      cpu_reset   <= 1'b1;
      cpu_running <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      btn_prev    <= db[0];
      btn_press   <= press_nxt;
      cpu_reset   <= (state_nxt != ST_RUN);
      cpu_running <= (state_nxt == ST_RUN);
    end
  end
endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: a segment table for press/release and
// switch debounce, plus hand sequences for bounce, re-press and mid-run reset.

module tb_input_conditioner;
  logic clk, reset_n;
  logic btn, sw, cpu_reset, cpu_running, btn_press, sw_clean;
  logic btn2, sw2, cpu_reset2, cpu_running2, btn_press2, sw_clean2;

  int checks = 0;
  int errors = 0;

  input_conditioner #(.DEBOUNCE_CYCLES(8), .RESET_HOLD_CYCLES(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .reset_btn(btn), .sw_raw(sw),
    .cpu_reset(cpu_reset), .cpu_running(cpu_running),
    .btn_press(btn_press), .sw_clean(sw_clean)
  );

  // Short debounce / long hold so a re-press can land inside STRETCH.
  input_conditioner #(.DEBOUNCE_CYCLES(2), .RESET_HOLD_CYCLES(8)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .reset_btn(btn2), .sw_raw(sw2),
    .cpu_reset(cpu_reset2), .cpu_running(cpu_running2),
    .btn_press(btn_press2), .sw_clean(sw_clean2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string tag, input logic r, input logic run,
                        input logic p, input logic s);
    check({tag, "_cpu_reset"},   cpu_reset,   r);
    check({tag, "_cpu_running"}, cpu_running, run);
    check({tag, "_btn_press"},   btn_press,   p);
    check({tag, "_sw_clean"},    sw_clean,    s);
  endtask

  typedef struct {
    logic btn;
    logic sw;
    int   n;
    logic rst;
    logic run;
    logic prs;
    logic swc;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // Segments run back to back; expectations hold after the last edge of each.
    tbl[0]  = '{1'b1, 1'b0, 10, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0,  1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0,  1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 38, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 10, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0,  1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0,  3, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0,  1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1,  9, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1,  1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0,  5, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 12, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0,  9, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0,  1, 1'b0, 1'b1, 1'b0, 1'b0};

    btn = 1'b0; sw = 1'b0; btn2 = 1'b0; sw2 = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check4("async_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    check("async_rst_cpu_reset2", cpu_reset2, 1'b1);

    repeat (3) tick();
    check4("in_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    // Power-on: RUN on the 4th edge after release.
    for (int k = 1; k <= 6; k++) begin
      tick();
      check4($sformatf("por_e%0d", k), (k < 4), (k >= 4), 1'b0, 1'b0);
    end

    // Clean press/release and switch debounce.
    for (int i = 0; i < 14; i++) begin
      btn = tbl[i].btn;
      sw  = tbl[i].sw;
      repeat (tbl[i].n) tick();
      check4($sformatf("tbl%0d", i), tbl[i].rst, tbl[i].run, tbl[i].prs, tbl[i].swc);
    end

    // Bounce: 3-cycle toggles never survive an 8-cycle debounce.
    for (int i = 0; i < 55; i++) begin
      btn = (i < 40) ? (((i / 3) % 2) == 0) : 1'b0;
      tick();
      check($sformatf("bounce_rst%0d", i), cpu_reset, 1'b0);
      check($sformatf("bounce_prs%0d", i), btn_press, 1'b0);
    end

    // Re-press during STRETCH on the second instance: presses at 4 and 16,
    // STRETCH at 14 is interrupted, final STRETCH at 24 ends at 32.
    for (int e = 0; e < 36; e++) begin
      btn2 = (e <= 9) || (e >= 12 && e <= 19);
      tick();
      check($sformatf("repress_rst%0d", e), cpu_reset2,   (e >= 4 && e < 32));
      check($sformatf("repress_run%0d", e), cpu_running2, !(e >= 4 && e < 32));
      check($sformatf("repress_prs%0d", e), btn_press2,   (e == 4 || e == 16));
    end

    // Reset mid-ASSERT with button and switch held.
    btn = 1'b1; sw = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      tick();
      check($sformatf("pre_prs%0d", e), btn_press, (e == 10));
      check($sformatf("pre_sw%0d", e),  sw_clean,  (e >= 9));
    end
    check("pre_rst", cpu_reset, 1'b1);
    reset_n = 1'b0;
    #2;
    check4("mid_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      check4($sformatf("post_e%0d", k), (k < 4 || k >= 11), (k >= 4 && k < 11),
             (k == 11), (k >= 10));
    end
    btn = 1'b0; sw = 1'b0;
    repeat (30) tick();
    check4("final", 1'b0, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
